otter_crypto_unit: RTL and testbench
====================================

Name: otter_crypto_unit

Overview:
- Multicycle cipher engine for the ENCRY custom instruction (opcode 7'b1011011), downstream of the control-unit decoder.
- Consumes the decoder's encrypt/decrypt select (func3 010 = encrypt, 011 = decrypt), rs1 as data and rs2 as key.
- Runs a 32-bit Feistel cipher, one round per clock.
- Result feeds register-file write mux input 4; the CU FSM stalls writeback on CRYPTO_BUSY.

Parameters:
- ROUNDS, 8: Feistel rounds per operation; legal 1..16.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- CRYPTO_START  in  1  start pulse from CU FSM; sampled only in IDLE
- CRYPTO_SEL  in  1  0 = encrypt, 1 = decrypt; sampled with START
- CRYPTO_DATA  in  32  rs1 operand; sampled with START
- CRYPTO_KEY  in  32  rs2 operand; sampled with START
- CRYPTO_RESULT  out  32  cipher/plain text; holds until next completion
- CRYPTO_BUSY  out  1  high whenever state != IDLE
- CRYPTO_DONE  out  1  one-cycle pulse in FINISH

Behaviour:
- Clock and reset: one clock (CLK). Reset is synchronous and active-high (RST).
- Reset values: state = IDLE, RESULT = 0, BUSY = 0, DONE = 0, round counter = 0, L = R = 0, latched key and sel = 0.
- Datapath: L = upper 16 bits, R = lower 16 bits. All arithmetic is 16-bit, modulo 2^16.
- Subkey k_i = (i even ? KEY[15:0] : KEY[31:16]) XOR i, with i zero-extended to 16 bits.
- F(x,k) = ((x rotl 3) + k) XOR (x >> 5), where >> is a logical shift.
- Encrypt, i = 0..ROUNDS-1: L' = R; R' = L XOR F(R,k_i).
- Decrypt, i = ROUNDS-1 down to 0: R' = L; L' = R XOR F(L,k_i). Decrypt exactly inverts encrypt for the same key and ROUNDS.
- FSM states: IDLE, RUN, FINISH.
- IDLE:
  - START = 1 at an edge: latch {L,R} = DATA, key, sel; counter = 0 (encrypt) or ROUNDS-1 (decrypt); go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - Each edge applies one round and steps the counter (+1 encrypt, -1 decrypt).
  - After the ROUNDS-th round edge, go to FINISH and load RESULT = {L,R} after the final round on that same edge.
- FINISH: DONE = 1 for exactly one cycle; next edge returns to IDLE unconditionally.
- Latency: START sampled at edge t. Rounds occur at edges t+1..t+ROUNDS. DONE and the new RESULT are visible in the cycle after edge t+ROUNDS. BUSY is high for ROUNDS+1 cycles.
- START while BUSY (RUN or FINISH) is ignored. Operands are not re-latched and no second operation is queued.
- DATA, KEY, SEL changes after the START edge have no effect on an operation in progress.
- RST mid-operation: next edge forces IDLE and all reset values, including RESULT = 0. No DONE pulse is produced for the aborted operation.
- RST and START in the same cycle: reset wins and START is dropped.
- Counter is 4 bits wide with no wrap beyond the ROUNDS bound. A decrypt counter reaching 0 ends the operation; it never underflows.
- ROUNDS = 1: exactly one RUN cycle.

Decomposition:
- Shared package otter_crypto_pkg:
  - crypto_state_t enum {IDLE, RUN, FINISH}.
  - Constants CRYPTO_ENC = 1'b0, CRYPTO_DEC = 1'b1, ENCRY_OPCODE = 7'b1011011.
  - RF_WR_SEL_CRYPTO = 3'd4.
  - Functions feistel_f(x,k) and subkey(key,i).
- One combinational sub-module, otter_crypto_round:
  - Inputs: L, R, subkey, sel.
  - Outputs: next L, next R for encrypt or decrypt direction.
  - The top block keeps the FSM, counter and registers.

Test Plan:
- Reset values: RST high 2 cycles -> RESULT = 0, BUSY = 0, DONE = 0. Hold START = 1 while RST = 1 -> stays IDLE.
- ROUNDS=1 encrypt: DATA = 0x00010002, KEY = 0, SEL = 0 -> DONE in cycle after edge t+1, RESULT = 0x00020011.
- ROUNDS=1 decrypt: DATA = 0x00020011, KEY = 0, SEL = 1 -> RESULT = 0x00010002.
- ROUNDS=2 encrypt: DATA = 0, KEY = 0 -> RESULT = 0x00000001. BUSY high exactly 3 cycles, DONE high exactly 1 cycle.
- Default ROUNDS=8 round-trip:
  - 200 random DATA/KEY pairs: encrypt then decrypt returns the original DATA.
  - DONE asserted exactly 9 cycles after each accepted START.
  - RESULT stable between operations.
- Robustness:
  - START pulsed again at cycle t+3 with different operands -> ignored; RESULT matches the first operands.
  - RST asserted at t+4 -> IDLE next cycle, RESULT = 0, no DONE pulse.

Source files
------------

// File: rtl/otter_crypto_pkg.sv
// rtl/otter_crypto_pkg.sv - shared types, constants and Feistel helpers for the ENCRY unit
package otter_crypto_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } crypto_state_t;

  localparam logic       CRYPTO_ENC       = 1'b0;
  localparam logic       CRYPTO_DEC       = 1'b1;
  localparam logic [6:0] ENCRY_OPCODE     = 7'b1011011;
  localparam logic [2:0] RF_WR_SEL_CRYPTO = 3'd4;

  // ((x rotl 3) + k) ^ (x >> 5), all modulo 2^16
  function automatic logic [15:0] feistel_f(input logic [15:0] x, input logic [15:0] k);
    logic [15:0] rot;
    rot = {x[12:0], x[15:13]};
    return (rot + k) ^ (x >> 5);
  endfunction

  // even rounds use the low key half, odd rounds the high half; round index folded in
  function automatic logic [15:0] subkey(input logic [31:0] key, input logic [3:0] i);
    return (i[0] ? key[31:16] : key[15:0]) ^ {12'd0, i};
  endfunction

endpackage

// File: rtl/otter_crypto_round.sv
// rtl/otter_crypto_round.sv - one combinational Feistel round, encrypt or decrypt direction
module otter_crypto_round
  import otter_crypto_pkg::*;
(
  input  logic [15:0] l_in,
  input  logic [15:0] r_in,
  input  logic [15:0] k_in,
  input  logic        sel,
  output logic [15:0] l_out,
  output logic [15:0] r_out
);

  always_comb begin
    l_out = l_in;
    r_out = r_in;
    if (sel == CRYPTO_ENC) begin
      l_out = r_in;
      r_out = l_in ^ feistel_f(r_in, k_in);
    end else begin
      r_out = l_in;
      l_out = r_in ^ feistel_f(l_in, k_in);
    end
  end

endmodule

// File: rtl/otter_crypto_unit.sv
// rtl/otter_crypto_unit.sv - multicycle 32-bit Feistel engine for the ENCRY instruction
module otter_crypto_unit
  import otter_crypto_pkg::*;
#(
  parameter int ROUNDS = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CRYPTO_START,
  input  logic        CRYPTO_SEL,
  input  logic [31:0] CRYPTO_DATA,
  input  logic [31:0] CRYPTO_KEY,
  output logic [31:0] CRYPTO_RESULT,
  output logic        CRYPTO_BUSY,
  output logic        CRYPTO_DONE
);

  localparam logic [3:0] LAST_IDX = 4'(ROUNDS - 1);

  crypto_state_t state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [15:0]   l_q, l_d, r_q, r_d;
  logic [31:0]   key_q, key_d;
  logic          sel_q, sel_d;
  logic [31:0]   result_q, result_d;
  logic [15:0]   l_nx, r_nx;
  logic          last_round;

  otter_crypto_round u_round (
    .l_in  (l_q),
    .r_in  (r_q),
    .k_in  (subkey(key_q, cnt_q)),
    .sel   (sel_q),
    .l_out (l_nx),
    .r_out (r_nx)
  );

  // decrypt counts down and finishes at 0, so the counter never underflows
  assign last_round = (sel_q == CRYPTO_DEC) ? (cnt_q == 4'd0) : (cnt_q == LAST_IDX);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    l_d      = l_q;
    r_d      = r_q;
    key_d    = key_q;
    sel_d    = sel_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (CRYPTO_START) begin
          l_d     = CRYPTO_DATA[31:16];
          r_d     = CRYPTO_DATA[15:0];
          key_d   = CRYPTO_KEY;
          sel_d   = CRYPTO_SEL;
          cnt_d   = (CRYPTO_SEL == CRYPTO_DEC) ? LAST_IDX : 4'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        l_d = l_nx;
        r_d = r_nx;
        if (last_round) begin
          result_d = {l_nx, r_nx};
          state_d  = FINISH;
        end else begin
          cnt_d = (sel_q == CRYPTO_DEC) ? cnt_q - 4'd1 : cnt_q + 4'd1;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      l_q      <= 16'd0;
      r_q      <= 16'd0;
      key_q    <= 32'd0;
      sel_q    <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      l_q      <= l_d;
      r_q      <= r_d;
      key_q    <= key_d;
      sel_q    <= sel_d;
      result_q <= result_d;
    end
  end

  assign CRYPTO_RESULT = result_q;
  assign CRYPTO_BUSY   = (state_q != IDLE);
  assign CRYPTO_DONE   = (state_q == FINISH);

endmodule

// File: tb/tb_otter_crypto_unit.sv
// tb/tb_otter_crypto_unit.sv - scoreboard bench over ROUNDS=1, 2 and 8 instances
module tb_otter_crypto_unit;

  typedef struct {
    logic [31:0] exp;
    int          due;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_s [3];
  logic        sel_s   [3];
  logic [31:0] data_s  [3];
  logic [31:0] key_s   [3];
  logic [31:0] res_s   [3];
  logic        busy_s  [3];
  logic        done_s  [3];
  logic [31:0] prev_res[3];
  logic        rst_prev = 1'b1;
  int          rounds_of[3];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          busy_cnt = 0;
  int          done_cnt = 0;
  exp_t        q0[$], q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  otter_crypto_unit #(.ROUNDS(1)) u_r1 (
    .CLK(clk), .RST(rst), .CRYPTO_START(start_s[0]), .CRYPTO_SEL(sel_s[0]),
    .CRYPTO_DATA(data_s[0]), .CRYPTO_KEY(key_s[0]), .CRYPTO_RESULT(res_s[0]),
    .CRYPTO_BUSY(busy_s[0]), .CRYPTO_DONE(done_s[0]));
  otter_crypto_unit #(.ROUNDS(2)) u_r2 (
    .CLK(clk), .RST(rst), .CRYPTO_START(start_s[1]), .CRYPTO_SEL(sel_s[1]),
    .CRYPTO_DATA(data_s[1]), .CRYPTO_KEY(key_s[1]), .CRYPTO_RESULT(res_s[1]),
    .CRYPTO_BUSY(busy_s[1]), .CRYPTO_DONE(done_s[1]));
  otter_crypto_unit u_r8 (
    .CLK(clk), .RST(rst), .CRYPTO_START(start_s[2]), .CRYPTO_SEL(sel_s[2]),
    .CRYPTO_DATA(data_s[2]), .CRYPTO_KEY(key_s[2]), .CRYPTO_RESULT(res_s[2]),
    .CRYPTO_BUSY(busy_s[2]), .CRYPTO_DONE(done_s[2]));

  function automatic logic [31:0] enc_model(input logic [31:0] d, input logic [31:0] k, input int n);
    logic [15:0] l, r, sk, f, t;
    l = d[31:16];
    r = d[15:0];
    for (int i = 0; i < n; i++) begin
      sk = (((i % 2) == 0) ? k[15:0] : k[31:16]) ^ 16'(i);
      f  = ((r << 3) | (r >> 13)) + sk;
      f  = f ^ (r >> 5);
      t  = r;
      r  = l ^ f;
      l  = t;
    end
    return {l, r};
  endfunction

  function automatic int qsize(input int u);
    case (u)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic void qpush(input int u, input exp_t e);
    case (u)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic exp_t qpop(input int u);
    case (u)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // monitor: every DONE pops one expectation; RESULT must not move otherwise
  always @(negedge clk) begin
    for (int u = 0; u < 3; u++) begin
      if (done_s[u]) begin
        checks++;
        if (qsize(u) == 0) begin
          errors++;
          $display("FAIL unexpected_done unit%0d result=%h", u, res_s[u]);
        end else begin
          exp_t e;
          e = qpop(u);
          if (res_s[u] !== e.exp) begin
            errors++;
            $display("FAIL %s result got=%h exp=%h", e.name, res_s[u], e.exp);
          end
          checks++;
          if (cyc != e.due) begin
            errors++;
            $display("FAIL %s done_cycle got=%0d exp=%0d", e.name, cyc, e.due);
          end
        end
      end else if (!rst_prev) begin
        checks++;
        if (res_s[u] !== prev_res[u]) begin
          errors++;
          $display("FAIL result_stable unit%0d got=%h exp=%h", u, res_s[u], prev_res[u]);
        end
      end
      prev_res[u] = res_s[u];
    end
    if (busy_s[1]) busy_cnt++;
    if (done_s[1]) done_cnt++;
    rst_prev = rst;
  end

  task automatic issue(input int u, input logic s, input logic [31:0] d, input logic [31:0] k,
                       input logic [31:0] ev, input string nm);
    exp_t e;
    @(posedge clk); #1;
    sel_s[u]   = s;
    data_s[u]  = d;
    key_s[u]   = k;
    start_s[u] = 1'b1;
    e.exp  = ev;
    e.due  = cyc + 1 + rounds_of[u];
    e.name = nm;
    qpush(u, e);
    @(posedge clk); #1;
    start_s[u] = 1'b0;
  endtask

  task automatic drain(input int u, input string nm);
    int n;
    n = 0;
    while (qsize(u) != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (qsize(u) != 0) begin
      errors++;
      $display("FAIL %s timeout pending=%0d exp=0", nm, qsize(u));
    end
  endtask

  task automatic check_val(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  initial begin
    logic [31:0] d, k, c;
    rounds_of[0] = 1;
    rounds_of[1] = 2;
    rounds_of[2] = 8;
    for (int u = 0; u < 3; u++) begin
      start_s[u] = 1'b1;
      sel_s[u]   = 1'b0;
      data_s[u]  = 32'hFFFF_FFFF;
      key_s[u]   = 32'h1234_5678;
      prev_res[u] = 32'd0;
    end

    // reset held two cycles with START also high
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      check_val($sformatf("reset_result_u%0d", u), res_s[u], 32'd0);
      check_val($sformatf("reset_busy_u%0d", u), {31'd0, busy_s[u]}, 32'd0);
      check_val($sformatf("reset_done_u%0d", u), {31'd0, done_s[u]}, 32'd0);
      start_s[u] = 1'b0;
    end
    rst = 1'b0;

    issue(0, 1'b0, 32'h0001_0002, 32'h0000_0000, 32'h0002_0011, "r1_enc");
    drain(0, "r1_enc");
    issue(0, 1'b1, 32'h0002_0011, 32'h0000_0000, 32'h0001_0002, "r1_dec");
    drain(0, "r1_dec");
    issue(0, 1'b0, 32'h1234_0001, 32'hFFFF_0005, 32'h0001_1239, "r1_enc_key");
    drain(0, "r1_enc_key");

    @(posedge clk); #1;
    busy_cnt = 0;
    done_cnt = 0;
    issue(1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001, "r2_enc");
    drain(1, "r2_enc");
    repeat (3) @(posedge clk);
    #1;
    check_val("r2_busy_cycles", busy_cnt, 32'd3);
    check_val("r2_done_cycles", done_cnt, 32'd1);

    for (int i = 0; i < 200; i++) begin
      d = $urandom;
      k = $urandom;
      c = enc_model(d, k, 8);
      issue(2, 1'b0, d, k, c, "rt_enc");
      drain(2, "rt_enc");
      issue(2, 1'b1, c, k, d, "rt_dec");
      drain(2, "rt_dec");
    end

    // second START mid-run with new operands must be ignored
    d = 32'hCAFE_BABE;
    k = 32'h1357_9BDF;
    issue(2, 1'b0, d, k, enc_model(d, k, 8), "restart_ignored");
    data_s[2] = 32'h0BAD_F00D;
    @(posedge clk); #1;
    start_s[2] = 1'b1;
    sel_s[2]   = 1'b1;
    data_s[2]  = 32'hDEAD_BEEF;
    key_s[2]   = 32'h0F0F_0F0F;
    @(posedge clk); #1;
    start_s[2] = 1'b0;
    drain(2, "restart_ignored");
    repeat (12) @(posedge clk);
    #1;
    check_val("restart_not_queued_busy", {31'd0, busy_s[2]}, 32'd0);

    // reset four edges into an operation aborts it without DONE
    @(posedge clk); #1;
    sel_s[2]   = 1'b0;
    data_s[2]  = 32'h2468_ACE0;
    key_s[2]   = 32'h9999_1111;
    start_s[2] = 1'b1;
    @(posedge clk); #1;
    start_s[2] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("abort_busy_before", {31'd0, busy_s[2]}, 32'd1);
    rst = 1'b1;
    start_s[2] = 1'b1;
    @(posedge clk); #1;
    check_val("abort_busy", {31'd0, busy_s[2]}, 32'd0);
    check_val("abort_result", res_s[2], 32'd0);
    check_val("abort_done", {31'd0, done_s[2]}, 32'd0);
    @(posedge clk); #1;
    check_val("rst_start_dropped", {31'd0, busy_s[2]}, 32'd0);
    rst = 1'b0;
    start_s[2] = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check_val("post_abort_idle", {31'd0, busy_s[2]}, 32'd0);
    check_val("post_abort_result", res_s[2], 32'd0);

    for (int u = 0; u < 3; u++) check_val($sformatf("sb_empty_u%0d", u), qsize(u), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
